rom_io_project_id: RTL and testbench

//   Program ROM plus 4-bit I/O port on the CPU's multiplexed 4-bit bus, directly downstream of the CPU core.

---
 rtl/rom_io_project_id.sv | 153 +++++++++++++++
 tb/tb_rom_io_project_id.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rom_io_project_id.sv
// Program ROM and 4-bit I/O port on the CPU's multiplexed nibble bus.
// Follows the 8-phase cycle from sync, answers fetches and SRC/WRR/RDR.
module rom_io_project_id #(
   parameter logic [3:0] CHIP_ID    = 4'h0,
   parameter logic [3:0] PORT_RESET = 4'h0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       halt,
   input  logic       sync,
   input  logic       rom_cmd,
   input  logic [3:0] data_i,
   output logic [3:0] data_o,
   output logic       data_en,
   input  logic       prog_we,
   input  logic [7:0] prog_addr,
   input  logic [7:0] prog_data,
   input  logic [3:0] io_in,
   output logic [3:0] io_out,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      PH_A1 = 3'd0,
      PH_A2 = 3'd1,
      PH_A3 = 3'd2,
      PH_M1 = 3'd3,
      PH_M2 = 3'd4,
      PH_X1 = 3'd5,
      PH_X2 = 3'd6,
      PH_X3 = 3'd7
   } phase_e;

   localparam logic [3:0] OP_WRR = 4'd2;
   localparam logic [3:0] OP_RDR = 4'd10;

   phase_e     phase_q, phase_d;
   logic       synced_q, synced_d;
   logic [7:0] addr_q, addr_d;
   logic       hit_q, hit_d;
   logic       sel_q, sel_d;
   logic [3:0] io_op_q, io_op_d;
   logic [3:0] io_out_q, io_out_d;

   logic [7:0] rom_q [256];
   logic [7:0] rom_byte;
   logic       fetch_m1;
   logic       fetch_m2;
   logic       rdr_x2;

   // Array is deliberately unreset and writable even while halted.
   always_ff @(posedge clock) begin
      if (prog_we) rom_q[prog_addr] <= prog_data;
   end

   assign rom_byte = rom_q[addr_q];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q  <= PH_X3;
         synced_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         synced_q <= synced_d;
      end
   end

   always_comb begin
      phase_d  = phase_q;
      synced_d = synced_q;
      if (!halt) begin
         if (sync) begin
            phase_d  = PH_A1;
            synced_d = 1'b1;
         end else if (phase_q != PH_X3) begin
            phase_d = phase_e'(phase_q + 3'd1);
         end else begin
            synced_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         addr_q   <= 8'h00;
         hit_q    <= 1'b0;
         sel_q    <= 1'b0;
         io_op_q  <= 4'h0;
         io_out_q <= PORT_RESET;
      end else begin
         addr_q   <= addr_d;
         hit_q    <= hit_d;
         sel_q    <= sel_d;
         io_op_q  <= io_op_d;
         io_out_q <= io_out_d;
      end
   end

   always_comb begin
      addr_d   = addr_q;
      hit_d    = hit_q;
      sel_d    = sel_q;
      io_op_d  = io_op_q;
      io_out_d = io_out_q;
      if (!halt) begin
         if (synced_q) begin
            case (phase_q)
               PH_A1:   addr_d[3:0] = data_i;
               PH_A2:   addr_d[7:4] = data_i;
               PH_A3:   hit_d = (data_i == CHIP_ID);
               default: ;
            endcase
         end
         if (phase_q == PH_M2) begin
            if (rom_cmd && sel_q && hit_q) io_op_d = rom_byte[3:0];
            else                           io_op_d = 4'h0;
         end
         // An SRC seen at X2 takes priority over a pending port op.
         if (phase_q == PH_X2) begin
            if (rom_cmd)                 sel_d    = (data_i == CHIP_ID);
            else if (io_op_q == OP_WRR)  io_out_d = data_i;
         end
      end
   end

   assign fetch_m1 = synced_q && hit_q && (phase_q == PH_M1);
   assign fetch_m2 = synced_q && hit_q && (phase_q == PH_M2);
   assign rdr_x2   = (phase_q == PH_X2) && (io_op_q == OP_RDR) && !rom_cmd;

   always_comb begin
      data_en = 1'b0;
      data_o  = 4'h0;
      unique case (1'b1)
         fetch_m1: begin
            data_en = 1'b1;
            data_o  = rom_byte[7:4];
         end
         fetch_m2: begin
            data_en = 1'b1;
            data_o  = rom_byte[3:0];
         end
         rdr_x2: begin
            data_en = 1'b1;
            data_o  = io_in;
         end
         default: ;
      endcase
   end

   assign io_out = io_out_q;
   assign phase  = phase_q;

endmodule

// File: tb/tb_rom_io_project_id.sv
// Scoreboard bench for rom_io_project_id: instruction-level model predicts
// bus nibbles into a queue, a negedge monitor pops them as the DUT drives.
module tb_rom_io_project_id;

   localparam logic [3:0] CID  = 4'h1;
   localparam logic [3:0] PRST = 4'hC;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       halt = 1'b0;
   logic       sync = 1'b0;
   logic       rom_cmd = 1'b0;
   logic [3:0] data_i = 4'h0;
   logic [3:0] data_o;
   logic       data_en;
   logic       prog_we = 1'b0;
   logic [7:0] prog_addr = 8'h00;
   logic [7:0] prog_data = 8'h00;
   logic [3:0] io_in = 4'h0;
   logic [3:0] io_out;
   logic [2:0] phase;

   rom_io_project_id #(.CHIP_ID(CID), .PORT_RESET(PRST)) dut (
      .clock(clock), .reset(reset), .halt(halt), .sync(sync),
      .rom_cmd(rom_cmd), .data_i(data_i), .data_o(data_o),
      .data_en(data_en), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .io_in(io_in), .io_out(io_out),
      .phase(phase)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [2:0] ph;
      logic [3:0] d;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] rom_m [256];
   logic       sel_m = 1'b0;
   logic [3:0] io_out_m = PRST;
   int         ph_m = 7;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Monitor: every driven nibble must match the next predicted one.
   always @(negedge clock) begin
      if (!reset && !halt) begin
         if (data_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_drive", {5'd0, phase}, 8'hFF);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("drive_phase", {5'd0, phase}, {5'd0, e.ph});
               chk("drive_data", {4'd0, data_o}, {4'd0, e.d});
            end
         end else begin
            chk("idle_data_o", {4'd0, data_o}, 8'h00);
         end
      end
   end

   task automatic step(input bit s, input bit c, input logic [3:0] d);
      sync = s;
      rom_cmd = c;
      data_i = d;
      @(posedge clock);
      #1;
      if (!halt) begin
         if (s) ph_m = 0;
         else if (ph_m < 7) ph_m = ph_m + 1;
      end
      chk("phase", {5'd0, phase}, ph_m[7:0]);
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] b);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = b;
      @(posedge clock);
      #1;
      prog_we = 1'b0;
      rom_m[a] = b;
   endtask

   task automatic queue_empty();
      chk("missing_drive", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);
      exp_q.delete();
   endtask

   // mode: 0 plain, 1 halt at M1, 2 reset during M2, 3 prog write at M1
   task automatic instr(input logic [11:0] a, input bit cm2, input bit x2c,
                        input logic [3:0] x2d, input logic [3:0] ioi,
                        input bit keep, input int mode,
                        input logic [7:0] newb);
      logic       hit;
      logic [7:0] b;
      logic [7:0] bb;
      logic [3:0] op;
      hit = (a[11:8] == CID);
      b = rom_m[a[7:0]];
      bb = (mode == 3) ? newb : b;
      io_in = ioi;
      if (hit) begin
         exp_q.push_back('{ph: 3'd3, d: b[7:4]});
         exp_q.push_back('{ph: 3'd4, d: bb[3:0]});
      end
      op = (cm2 && sel_m && hit) ? bb[3:0] : 4'h0;
      if (mode != 2) begin
         if (x2c) sel_m = (x2d == CID);
         else if (op == 4'd2) io_out_m = x2d;
         else if (op == 4'd10) exp_q.push_back('{ph: 3'd6, d: ioi});
      end
      step(1'b0, 1'b0, a[3:0]);
      step(1'b0, 1'b0, a[7:4]);
      step(1'b0, 1'b0, a[11:8]);
      if (mode == 1) begin
         halt = 1'b1;
         for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'($urandom));
            chk("halt_en", {7'd0, data_en}, {7'd0, hit});
            chk("halt_data", {4'd0, data_o}, hit ? {4'd0, b[7:4]} : 8'd0);
         end
         halt = 1'b0;
      end
      if (mode == 3) begin
         prog_we = 1'b1;
         prog_addr = a[7:0];
         prog_data = newb;
         step(1'b0, 1'b0, 4'($urandom));
         prog_we = 1'b0;
         rom_m[a[7:0]] = newb;
      end else begin
         step(1'b0, 1'b0, 4'($urandom));
      end
      if (mode == 2) begin
         rom_cmd = cm2;
         @(negedge clock);
         #1;
         reset = 1'b1;
         #1;
         chk("rst_data_en", {7'd0, data_en}, 8'd0);
         chk("rst_phase", {5'd0, phase}, 8'd7);
         chk("rst_io_out", {4'd0, io_out}, {4'd0, PRST});
         @(posedge clock);
         #1;
         reset = 1'b0;
         rom_cmd = 1'b0;
         sel_m = 1'b0;
         io_out_m = PRST;
         ph_m = 7;
         queue_empty();
         return;
      end
      step(1'b0, cm2, 4'($urandom));
      step(1'b0, 1'b0, 4'($urandom));
      step(1'b0, x2c, x2d);
      chk("io_out", {4'd0, io_out}, {4'd0, io_out_m});
      step(keep, 1'b0, 4'($urandom));
      queue_empty();
   endtask

   initial begin
      logic [7:0] rb;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_phase", {5'd0, phase}, 8'd7);
      chk("reset_data_en", {7'd0, data_en}, 8'd0);
      chk("reset_data_o", {4'd0, data_o}, 8'd0);
      chk("reset_io_out", {4'd0, io_out}, {4'd0, PRST});
      reset = 1'b0;

      for (int i = 0; i < 256; i++) begin
         case ($urandom_range(0, 3))
            0: rb = 8'hE2;
            1: rb = 8'hEA;
            default: rb = 8'($urandom);
         endcase
         load(8'(i), rb);
      end
      load(8'h12, 8'hA5);
      load(8'h34, 8'hE2);
      load(8'h56, 8'hEA);

      step(1'b1, 1'b0, 4'h0);
      instr(12'h112, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00);
      instr(12'h312, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00);
      instr(12'h312, 0, 1, 4'h1, 4'h0, 1, 0, 8'h00);
      instr(12'h134, 1, 0, 4'h9, 4'h0, 1, 0, 8'h00);
      instr(12'h156, 1, 0, 4'h3, 4'h6, 1, 0, 8'h00);
      instr(12'h312, 0, 1, 4'h4, 4'h0, 1, 0, 8'h00);
      instr(12'h134, 1, 0, 4'h5, 4'h0, 0, 0, 8'h00);

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'($urandom));
      step(1'b1, 1'b0, 4'h0);
      instr(12'h112, 0, 0, 4'h0, 4'h0, 1, 1, 8'h00);
      instr(12'h1AB, 0, 0, 4'h0, 4'h0, 1, 3, 8'h3C);

      for (int i = 0; i < 80; i++) begin
         logic [11:0] a;
         a[7:0] = 8'($urandom);
         a[11:8] = $urandom_range(0, 1) ? CID : 4'($urandom);
         instr(a, 1'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 1) ? CID : 4'($urandom),
               4'($urandom), 1, 0, 8'h00);
      end

      instr(12'h312, 0, 1, 4'h1, 4'h0, 1, 0, 8'h00);
      instr(12'h134, 1, 0, 4'h7, 4'h0, 1, 2, 8'h00);
      step(1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 4'h0);
      instr(12'h112, 0, 0, 4'h0, 4'h0, 1, 0, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
